rob_ring: RTL and testbench

Parametrised in-order reorder buffer ring for the Jellycore out-of-order core. It sits between the dispatcher and the commit stage. It accepts up to DISPATCH_W instructions per cycle and tracks completion writebacks from CMPL_W execution ports. It retires up to COMMIT_W oldest completed instructions per cycle in program order, and discards all contents on a memory-order-violation flush.

---
 rtl/rob_ring.sv | 127 ++++++++++++
 tb/tb_rob_ring.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_ring.sv
// In-order reorder buffer ring: multi-lane dispatch at the tail, out-of-order
// completion marking, and in-order multi-lane retirement from the head.
module rob_ring #(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int DISPATCH_W = 2,
    parameter int COMMIT_W   = 2,
    parameter int CMPL_W     = 2,
    parameter int PAYLOAD_W  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DISPATCH_W-1:0]           dispatch_valid,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload,
    output logic                            dispatch_ready,
    output logic [DISPATCH_W*IDX_W-1:0]     dispatch_idx,
    input  logic [CMPL_W-1:0]               cmpl_valid,
    input  logic [CMPL_W*IDX_W-1:0]         cmpl_idx,
    input  logic                            commit_stall,
    output logic [COMMIT_W-1:0]             commit_valid,
    output logic [COMMIT_W*IDX_W-1:0]       commit_idx,
    output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload,
    input  logic                            flush,
    output logic                            rob_full,
    output logic                            rob_empty,
    output logic [IDX_W:0]                  rob_count
);
    localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - DISPATCH_W);
    localparam logic [IDX_W:0] ONE       = (IDX_W+1)'(1);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     done_q;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [IDX_W-1:0]     head_q;
    logic [IDX_W-1:0]     tail_q;
    logic [IDX_W:0]       count_q;

    logic [IDX_W:0]       n_disp;
    logic [IDX_W:0]       n_commit;
    logic [IDX_W-1:0]     disp_slot [DISPATCH_W];
    logic [IDX_W-1:0]     commit_slot [COMMIT_W];
    logic                 commit_ok;

    // Handshakes: dispatch lane i is taken when dispatch_valid[i] && dispatch_ready
    // (otherwise the dispatcher holds it); commit lane k retires whenever
    // commit_valid[k] is high, which already folds in !commit_stall and !flush.
    assign dispatch_ready = (count_q <= READY_MAX);
    assign rob_full       = (count_q == DEPTH_C);
    assign rob_empty      = (count_q == '0);
    assign rob_count      = count_q;

    always_comb begin
        n_disp       = '0;
        dispatch_idx = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            disp_slot[i] = tail_q + IDX_W'(i);
            dispatch_idx[i*IDX_W +: IDX_W] = disp_slot[i];
            if (dispatch_ready && dispatch_valid[i])
                n_disp = n_disp + ONE;
        end
    end

    // A lane may retire only if every older lane in the window retires too.
    always_comb begin
        commit_ok      = !commit_stall && !flush;
        n_commit       = '0;
        commit_valid   = '0;
        commit_idx     = '0;
        commit_payload = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            commit_slot[k] = head_q + IDX_W'(k);
            commit_idx[k*IDX_W +: IDX_W]         = commit_slot[k];
            commit_payload[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[commit_slot[k]];
            commit_ok = commit_ok && valid_q[commit_slot[k]] && done_q[commit_slot[k]]
                        && ((IDX_W+1)'(k) < count_q);
            commit_valid[k] = commit_ok;
            if (commit_ok)
                n_commit = n_commit + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int j = 0; j < CMPL_W; j++) begin
                if (cmpl_valid[j] && valid_q[cmpl_idx[j*IDX_W +: IDX_W]])
                    done_q[cmpl_idx[j*IDX_W +: IDX_W]] <= 1'b1;
            end
            for (int i = 0; i < DISPATCH_W; i++) begin
                if (dispatch_ready && dispatch_valid[i]) begin
                    valid_q[disp_slot[i]] <= 1'b1;
                    done_q[disp_slot[i]]  <= 1'b0;
                end
            end
            // Retirement is applied last so a same-cycle completion cannot revive it.
            for (int k = 0; k < COMMIT_W; k++) begin
                if (commit_valid[k]) begin
                    valid_q[commit_slot[k]] <= 1'b0;
                    done_q[commit_slot[k]]  <= 1'b0;
                end
            end
            head_q  <= head_q + n_commit[IDX_W-1:0];
            tail_q  <= tail_q + n_disp[IDX_W-1:0];
            count_q <= count_q + n_disp - n_commit;
        end
    end

    // Payload storage needs no reset: it is only observed behind valid entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (dispatch_ready && dispatch_valid[i] && !flush)
                payload_q[disp_slot[i]] <= dispatch_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end
endmodule

// File: tb/tb_rob_ring.sv
// Bench for rob_ring at DEPTH=8: mid-run reset, a directed vector table, and a
// randomized phase scored against a queue-based program-order model.
`timescale 1ns/1ps
module tb_rob_ring;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int DW    = 2;
    localparam int CW    = 2;
    localparam int PW    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DW-1:0]     dispatch_valid;
    logic [DW*PW-1:0]  dispatch_payload;
    logic              dispatch_ready;
    logic [DW*IDX_W-1:0] dispatch_idx;
    logic [1:0]        cmpl_valid;
    logic [2*IDX_W-1:0] cmpl_idx;
    logic              commit_stall;
    logic [CW-1:0]     commit_valid;
    logic [CW*IDX_W-1:0] commit_idx;
    logic [CW*PW-1:0]  commit_payload;
    logic              flush;
    logic              rob_full;
    logic              rob_empty;
    logic [IDX_W:0]    rob_count;

    rob_ring #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DISPATCH_W(DW), .COMMIT_W(CW),
        .CMPL_W(2), .PAYLOAD_W(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_payload(dispatch_payload),
        .dispatch_ready(dispatch_ready), .dispatch_idx(dispatch_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .commit_stall(commit_stall), .commit_valid(commit_valid),
        .commit_idx(commit_idx), .commit_payload(commit_payload),
        .flush(flush), .rob_full(rob_full), .rob_empty(rob_empty),
        .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] dv;
        logic [1:0] cv;
        logic [5:0] ci;
        logic       st;
        logic       fl;
        int         cnt;
        logic [1:0] ecv;
        logic [5:0] ecidx;
        logic [5:0] edidx;
        logic       erdy;
    } vec_t;

    vec_t vq[$];

    // Program-order model: one element per occupied entry, oldest first.
    logic [PW-1:0]    exp_q[$];
    logic [IDX_W-1:0] idx_q[$];
    bit               done_q[$];
    int               m_tail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] pk(input int l1, input int l0);
        return {3'(l1), 3'(l0)};
    endfunction

    function automatic vec_t mk(input logic [1:0] dv, input logic [1:0] cv, input logic [5:0] ci,
                                input logic st, input logic fl, input int cnt, input logic [1:0] ecv,
                                input logic [5:0] ecidx, input logic [5:0] edidx, input logic erdy);
        vec_t v;
        v.dv = dv; v.cv = cv; v.ci = ci; v.st = st; v.fl = fl;
        v.cnt = cnt; v.ecv = ecv; v.ecidx = ecidx; v.edidx = edidx; v.erdy = erdy;
        return v;
    endfunction

    task automatic drive(input logic [1:0] dv, input logic [15:0] dp, input logic [1:0] cv,
                         input logic [5:0] ci, input logic st, input logic fl);
        dispatch_valid   = dv;
        dispatch_payload = dp;
        cmpl_valid       = cv;
        cmpl_idx         = ci;
        commit_stall     = st;
        flush            = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(2'b00, 16'h0, 2'b00, 6'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.empty", 32'(rob_empty), 32'd1);
        chk("rst.ready", 32'(dispatch_ready), 32'd1);

        // Fill five entries, complete the oldest two, then reset mid-cycle.
        drive(2'b11, 16'h1110, 2'b00, 6'h0, 1'b0, 1'b0); tick();
        drive(2'b11, 16'h1312, 2'b00, 6'h0, 1'b0, 1'b0); tick();
        drive(2'b01, 16'h0014, 2'b00, 6'h0, 1'b0, 1'b0); tick();
        drive(2'b00, 16'h0000, 2'b11, pk(1, 0), 1'b0, 1'b0); tick();
        drive(2'b00, 16'h0000, 2'b00, 6'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst.count", 32'(rob_count), 32'd5);
        chk("pre_rst.cv", 32'(commit_valid), 32'd3);
        chk("pre_rst.payload", 32'(commit_payload), 32'h1110);
        reset = 1'b1;
        #1;
        chk("mid_rst.empty", 32'(rob_empty), 32'd1);
        chk("mid_rst.count", 32'(rob_count), 32'd0);
        chk("mid_rst.cv", 32'(commit_valid), 32'd0);
        chk("mid_rst.full", 32'(rob_full), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst.didx", 32'(dispatch_idx), 32'(pk(1, 0)));
        chk("post_rst.cidx", 32'(commit_idx), 32'(pk(1, 0)));
        chk("post_rst.ready", 32'(dispatch_ready), 32'd1);

        // dv, cv, ci, stall, flush | count, commit_valid, commit_idx, dispatch_idx, ready
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 2, 2'b00, 6'h0,     pk(3, 2), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 4, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 6, 2'b00, 6'h0,     pk(7, 6), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 8, 2'b00, 6'h0,     pk(1, 0), 0));
        vq.push_back(mk(2'b00, 2'b11, pk(1, 0), 0, 0, 8, 2'b00, 6'h0,     pk(1, 0), 0));
        vq.push_back(mk(2'b00, 2'b11, pk(3, 2), 0, 0, 8, 2'b11, pk(1, 0), pk(1, 0), 0));
        vq.push_back(mk(2'b00, 2'b11, pk(5, 4), 0, 0, 6, 2'b11, pk(3, 2), pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b11, pk(7, 6), 0, 0, 4, 2'b11, pk(5, 4), pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 2, 2'b11, pk(7, 6), pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 2, 2'b00, 6'h0,     pk(3, 2), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 2), 0, 0, 4, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 3), 0, 0, 4, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 1), 0, 0, 4, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 0), 0, 0, 4, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 4, 2'b11, pk(1, 0), pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 2, 2'b11, pk(3, 2), pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(5, 4), 1));
        vq.push_back(mk(2'b00, 2'b11, pk(5, 4), 0, 0, 2, 2'b00, 6'h0,     pk(7, 6), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     1, 0, 2, 2'b00, 6'h0,     pk(7, 6), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     1, 0, 2, 2'b00, 6'h0,     pk(7, 6), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     1, 0, 2, 2'b00, 6'h0,     pk(7, 6), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 2, 2'b11, pk(5, 4), pk(7, 6), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 6), 0, 0, 2, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 2, 2'b01, pk(0, 6), pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b01, pk(0, 7), 0, 0, 1, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     1, 0, 1, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b01, 2'b01, pk(0, 0), 1, 0, 3, 2'b00, 6'h0,     pk(3, 2), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 4, 2'b11, pk(0, 7), pk(4, 3), 1));
        vq.push_back(mk(2'b00, 2'b11, pk(2, 1), 0, 0, 4, 2'b00, 6'h0,     pk(6, 5), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 4, 2'b11, pk(2, 1), pk(6, 5), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 2, 2'b00, 6'h0,     pk(6, 5), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 4, 2'b00, 6'h0,     pk(0, 7), 1));
        vq.push_back(mk(2'b00, 2'b11, pk(4, 3), 0, 0, 6, 2'b00, 6'h0,     pk(2, 1), 1));
        vq.push_back(mk(2'b11, 2'b11, pk(0, 7), 0, 1, 6, 2'b00, 6'h0,     pk(2, 1), 1));
        vq.push_back(mk(2'b11, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(1, 0), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 2, 2'b00, 6'h0,     pk(3, 2), 1));
        vq.push_back(mk(2'b00, 2'b11, pk(1, 0), 0, 0, 2, 2'b00, 6'h0,     pk(3, 2), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 2, 2'b11, pk(1, 0), pk(3, 2), 1));
        vq.push_back(mk(2'b00, 2'b00, 6'h0,     0, 0, 0, 2'b00, 6'h0,     pk(3, 2), 1));

        for (int r = 0; r < vq.size(); r++) begin
            drive(vq[r].dv, 16'($urandom), vq[r].cv, vq[r].ci, vq[r].st, vq[r].fl);
            #1;
            chk($sformatf("v%0d.count", r), 32'(rob_count), 32'(vq[r].cnt));
            chk($sformatf("v%0d.full", r), 32'(rob_full), 32'(vq[r].cnt == DEPTH));
            chk($sformatf("v%0d.empty", r), 32'(rob_empty), 32'(vq[r].cnt == 0));
            chk($sformatf("v%0d.ready", r), 32'(dispatch_ready), 32'(vq[r].erdy));
            chk($sformatf("v%0d.cv", r), 32'(commit_valid), 32'(vq[r].ecv));
            chk($sformatf("v%0d.didx", r), 32'(dispatch_idx), 32'(vq[r].edidx));
            for (int k = 0; k < CW; k++) begin
                if (vq[r].ecv[k])
                    chk($sformatf("v%0d.cidx%0d", r, k), 32'(commit_idx[k*IDX_W +: IDX_W]),
                        32'(vq[r].ecidx[k*IDX_W +: IDX_W]));
            end
            tick();
        end

        // Randomized phase against the program-order model.
        drive(2'b00, 16'h0, 2'b00, 6'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_tail = 0;
        for (int c = 0; c < 800; c++) begin
            logic [1:0]  dv;
            logic [1:0]  cv;
            logic [5:0]  ci;
            logic [15:0] dp;
            logic        st;
            logic        fl;
            logic        e_rdy;
            logic        ok;
            int          sz;
            int          ncom;
            int          sel;
            sel = $urandom_range(0, 2);
            dv  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
            dp  = 16'($urandom);
            cv  = 2'b00;
            ci  = 6'h0;
            if (idx_q.size() > 0) begin
                cv = 2'($urandom);
                ci = {idx_q[$urandom_range(0, idx_q.size() - 1)],
                      idx_q[$urandom_range(0, idx_q.size() - 1)]};
            end
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 49) == 0);
            drive(dv, dp, cv, ci, st, fl);
            #1;
            sz    = idx_q.size();
            e_rdy = ((DEPTH - sz) >= DW);
            chk("rnd.count", 32'(rob_count), 32'(sz));
            chk("rnd.ready", 32'(dispatch_ready), 32'(e_rdy));
            chk("rnd.full", 32'(rob_full), 32'(sz == DEPTH));
            chk("rnd.empty", 32'(rob_empty), 32'(sz == 0));
            for (int i = 0; i < DW; i++)
                chk($sformatf("rnd.didx%0d", i), 32'(dispatch_idx[i*IDX_W +: IDX_W]),
                    32'((m_tail + i) % DEPTH));
            ok   = !st && !fl;
            ncom = 0;
            for (int k = 0; k < CW; k++) begin
                ok = ok && (k < sz) && done_q[k];
                chk($sformatf("rnd.cv%0d", k), 32'(commit_valid[k]), 32'(ok));
                if (ok) begin
                    chk($sformatf("rnd.cidx%0d", k), 32'(commit_idx[k*IDX_W +: IDX_W]), 32'(idx_q[k]));
                    chk($sformatf("rnd.payload%0d", k), 32'(commit_payload[k*PW +: PW]), 32'(exp_q[k]));
                    ncom++;
                end
            end
            tick();
            if (fl) begin
                exp_q.delete();
                idx_q.delete();
                done_q.delete();
                m_tail = 0;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (cv[j]) begin
                        for (int e = 0; e < idx_q.size(); e++)
                            if (idx_q[e] == ci[j*IDX_W +: IDX_W]) done_q[e] = 1'b1;
                    end
                end
                repeat (ncom) begin
                    void'(exp_q.pop_front());
                    void'(idx_q.pop_front());
                    void'(done_q.pop_front());
                end
                if (e_rdy) begin
                    for (int i = 0; i < DW; i++) begin
                        if (dv[i]) begin
                            exp_q.push_back(dp[i*PW +: PW]);
                            idx_q.push_back(3'(m_tail));
                            done_q.push_back(1'b0);
                            m_tail = (m_tail + 1) % DEPTH;
                        end
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
